// File: rtl/data_mem_bist.sv
// rtl/data_mem_bist.sv - March-style BIST initiator for the data memory port.
// Drives the CPU-side memory interface, honours clk_stall and reports pass/fail.
module data_mem_bist #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
  parameter logic [3:0]  WORD_MASK = 4'b0111,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [31:0] LAST_IDX   = 32'(NUM_WORDS - 1);
  localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  elem;
  logic [31:0] idx;
  logic [31:0] word_addr;
  logic [31:0] wait_cnt;
  logic [31:0] rdata_q;

  logic        nxt_finish;
  logic [1:0]  nxt_elem;
  logic [31:0] nxt_idx;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_pat;
  logic [31:0] cur_pat;

  assign mem_sign_mask = WORD_MASK;

  // Elements 2 and 3 use the inverted pattern; odd elements are reads.
  always_comb begin
    nxt_finish = 1'b0;
    nxt_elem   = elem;
    nxt_idx    = idx + 32'd1;
    nxt_addr   = word_addr + 32'd4;
    if (idx == LAST_IDX) begin
      nxt_idx  = '0;
      nxt_addr = BASE_ADDR;
      if (elem == 2'd3) nxt_finish = 1'b1;
      else              nxt_elem   = elem + 2'd1;
    end
    nxt_pat = nxt_addr ^ SEED;
    if (nxt_elem[1]) nxt_pat = ~nxt_pat;
    cur_pat = word_addr ^ SEED;
    if (elem[1]) cur_pat = ~cur_pat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      elem      <= '0;
      idx       <= '0;
      word_addr <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            elem      <= '0;
            idx       <= '0;
            word_addr <= BASE_ADDR;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= BASE_ADDR ^ SEED;
            mem_write <= 1'b1;
            mem_read  <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!mem_stall) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            rdata_q   <= mem_rdata;
            state     <= elem[0] ? S_CHECK : S_NEXT;
          end else if (wait_cnt == WAIT_LIMIT) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FINISH;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          if (rdata_q != cur_pat) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) begin
              fail_addr <= word_addr;
              fail_data <= rdata_q;
            end
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (nxt_finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
            state <= S_FINISH;
          end else begin
            elem      <= nxt_elem;
            idx       <= nxt_idx;
            word_addr <= nxt_addr;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_pat;
            mem_write <= ~nxt_elem[0];
            mem_read  <= nxt_elem[0];
            state     <= S_ISSUE;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bist.sv
// tb/tb_data_mem_bist.sv - Self-checking bench for data_mem_bist with a stalling memory model.
module tb_data_mem_bist;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam int          NW   = 4;
  localparam int          TMO  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] fail_addr, fail_data, mem_addr, mem_wdata;
  logic        mem_write, mem_read;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata = '0;
  logic        mem_stall = 1'b0;

  always #5 clk = ~clk;

  data_mem_bist #(
    .BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED), .WORD_MASK(4'b0111), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_sign_mask(mem_sign_mask), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } acc_t;

  acc_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Memory model: one word per tested address, optional bit0 stuck-at-1 on 0x1008.
  logic [31:0] mem [0:NW-1];
  bit          stuck     = 1'b0;
  bit          rand_mode = 1'b0;
  int          stall_n   = 1;
  int          hang_acc  = -1;
  int          drv_acc   = 0;
  int          k         = 0;
  int          cur_n     = 0;
  bit          in_acc    = 1'b0;

  always @(negedge clk) begin : mem_model
    int wi;
    wi = int'((mem_addr - BASE) >> 2);
    if (wi < 0 || wi >= NW) wi = 0;
    if (mem_read || mem_write) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        k = 0;
        drv_acc++;
        if (drv_acc == hang_acc) cur_n = 100000;
        else if (rand_mode)      cur_n = int'($urandom_range(0, 5));
        else                     cur_n = stall_n;
      end else begin
        k++;
      end
      mem_stall = (k <= cur_n);
      mem_rdata = mem[wi] | ((stuck && mem_addr == 32'h1008) ? 32'h1 : 32'h0);
      if (mem_write && k >= 1 && !mem_stall) mem[wi] = mem_wdata;
    end else begin
      in_acc    = 1'b0;
      mem_stall = 1'b1;
    end
  end

  // Compare process: every access against the expected march sequence.
  bit          ck_active = 1'b0;
  int          alen      = 0;
  int          acc_run   = 0;
  logic [31:0] first_addr, first_wdata, hold_addr, hold_wdata;
  logic [1:0]  hold_str;

  always @(negedge clk) begin : compare
    acc_t e;
    if (!rst_n) begin
      ck_active = 1'b0;
      alen = 0;
    end else begin
      chk("both_strobes", 32'(mem_read & mem_write), 32'd0);
      if (!busy) chk("idle_strobes", 32'({mem_read, mem_write}), 32'd0);
      if (mem_read || mem_write) begin
        chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
        if (!ck_active) begin
          ck_active = 1'b1;
          alen = 1;
          acc_run++;
          if (acc_run == 1) begin
            first_addr  = mem_addr;
            first_wdata = mem_wdata;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_access", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("acc_addr", mem_addr, e.addr);
            chk("acc_is_write", 32'(mem_write), 32'(e.wr));
            if (e.wr) chk("acc_wdata", mem_wdata, e.data);
          end
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
          hold_str   = {mem_read, mem_write};
        end else begin
          alen++;
          chk("stable_addr", mem_addr, hold_addr);
          chk("stable_wdata", mem_wdata, hold_wdata);
          chk("stable_strobe", 32'({mem_read, mem_write}), 32'(hold_str));
        end
      end else if (ck_active) begin
        ck_active = 1'b0;
        chk("access_len", 32'(alen), 32'((cur_n >= TMO) ? TMO + 1 : cur_n + 2));
      end
    end
  end

  task automatic build_q();
    acc_t a;
    exp_q.delete();
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < NW; i++) begin
        a.addr = BASE + 32'(4 * i);
        a.data = (e >= 2) ? ~(a.addr ^ SEED) : (a.addr ^ SEED);
        a.wr   = (e % 2) == 0;
        exp_q.push_back(a);
      end
  endtask

  task automatic model_run(input bit stk, output int errs, output logic [31:0] fa,
                           output logic [31:0] fd);
    logic [31:0] m [0:NW-1];
    logic [31:0] a, p, got;
    errs = 0; fa = '0; fd = '0;
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < NW; i++) begin
        a = BASE + 32'(4 * i);
        p = (e >= 2) ? ~(a ^ SEED) : (a ^ SEED);
        if (e % 2 == 0) m[i] = p;
        else begin
          got = m[i] | ((stk && a == 32'h1008) ? 32'h1 : 32'h0);
          if (got != p) begin
            if (errs == 0) begin fa = a; fd = got; end
            errs++;
          end
        end
      end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_within_budget", 32'd0, 32'd1);
  endtask

  task automatic begin_run();
    build_q();
    acc_run = 0;
    drv_acc = 0;
    pulse_start();
  endtask

  task automatic check_clean(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd1);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fail_addr"}, fail_addr, 32'd0);
    chk({tag, "_accesses"}, 32'(acc_run), 32'd16);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  int          m_err;
  logic [31:0] m_fa, m_fd;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fail_addr", fail_addr, 32'd0);
    chk("rst_fail_data", fail_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mask", 32'(mem_sign_mask), 32'h7);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_stall_ignored", 32'(busy), 32'd0);

    // 1: one stall cycle per access, clean memory
    stall_n = 1;
    begin_run();
    wait_done(2000);
    check_clean("t1");
    chk("t1_first_addr", first_addr, 32'h0000_1000);
    chk("t1_first_wdata", first_wdata, 32'hA5A5_4A5A);

    // 2: bit0 stuck-at-1 at 0x1008, visible only where the pattern has bit0=0
    stuck = 1'b1;
    begin_run();
    wait_done(2000);
    model_run(1'b1, m_err, m_fa, m_fd);
    chk("t2_model_err", 32'(m_err), 32'd1);
    chk("t2_model_fa", m_fa, 32'h0000_1008);
    chk("t2_model_fd", m_fd, 32'hA5A5_4A53);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_err", 32'(err_count), 32'(m_err));
    chk("t2_fail_addr", fail_addr, m_fa);
    chk("t2_fail_data", fail_data, m_fd);
    chk("t2_timeout", 32'(timeout), 32'd0);
    stuck = 1'b0;

    // 3: third access stalls forever
    hang_acc = 3;
    build_q();
    acc_run = 0;
    drv_acc = 0;
    hang_acc = 3;
    pulse_start();
    wait_done(2000);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("t3_accesses", 32'(acc_run), 32'd3);
    hang_acc = -1;

    // 4: random 0..5 stalls, two runs
    rand_mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      begin_run();
      wait_done(3000);
      check_clean("t4");
    end
    rand_mode = 1'b0;

    // 5: reset during WAIT of access 7, then a clean run
    stall_n = 2;
    begin_run();
    for (int c = 0; c < 1000 && !(acc_run == 7 && alen >= 2); c++) @(negedge clk);
    chk("t5_reached_acc7", 32'(acc_run == 7 && alen >= 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_addr", mem_addr, 32'd0);
    chk("t5_err", 32'(err_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    begin_run();
    wait_done(2000);
    check_clean("t5");

    // 6: start while busy and in FINISH ignored; start after done restarts
    stall_n = 0;
    begin_run();
    repeat (10) @(negedge clk);
    pulse_start();
    for (int c = 0; c < 2000 && !done; c++) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check_clean("t6");
    begin_run();
    chk("t6_restart_busy", 32'(busy), 32'd1);
    chk("t6_restart_done", 32'(done), 32'd0);
    wait_done(2000);
    check_clean("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
